// File: rtl/ace_rom_bus_if.sv
// ace_rom_bus_if: Jupiter Ace CPU-to-ROM read bridge (clk, rst, cpu_a/mreq_n/rd_n/wr_n in; rom_a out, rom_dout in; cpu_din/rom_sel/cpu_wait_n/wr_viol out); ACE_ROM_WAIT_EN enables cpu_wait_n stretching
module ace_rom_bus_if #(
  parameter logic [2:0] ROM_BASE_HI = 3'b000,
  parameter logic [7:0] IDLE_DATA = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_a,
  input  logic        cpu_mreq_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  output logic [12:0] rom_a,
  input  logic [7:0]  rom_dout,
  output logic [7:0]  cpu_din,
  output logic        rom_sel,
  output logic        cpu_wait_n,
  output logic        wr_viol
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, CAPTURE = 2'd2, HOLD = 2'd3;
  logic [1:0] state, state_d;
  logic hit, rd_act, wr_act, rd_act_q, wr_act_q, rd_start, wr_start;
  logic [7:0] data_q;
  assign hit = (cpu_a[15:13] == ROM_BASE_HI) && !cpu_mreq_n;
  assign rd_act = hit && !cpu_rd_n;
  assign wr_act = hit && !cpu_wr_n;
  assign rd_start = rd_act && !rd_act_q;
  assign wr_start = wr_act && !wr_act_q;
  assign rom_sel = state == HOLD;
  assign cpu_din = rom_sel ? data_q : IDLE_DATA;
  always_comb
    state_d = state == IDLE ? (rd_start ? ISSUE : IDLE) :
              !rd_act ? IDLE :
              state == HOLD ? HOLD : state + 2'd1;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      rom_a <= '0;
      data_q <= 8'hFF;
      rd_act_q <= 1'b0;
      wr_act_q <= 1'b0;
      wr_viol <= 1'b0;
    end else begin
      state <= state_d;
      rd_act_q <= rd_act;
      wr_act_q <= wr_act;
      wr_viol <= wr_start;
      if (state == IDLE && rd_start) rom_a <= cpu_a[12:0];
      if (state == CAPTURE && rd_act) data_q <= rom_dout;
    end
`ifdef ACE_ROM_WAIT_EN
  always_ff @(posedge clk)
    if (rst) cpu_wait_n <= 1'b1;
    else cpu_wait_n <= !(state_d == ISSUE || state_d == CAPTURE);
`else
  assign cpu_wait_n = 1'b1;
`endif
endmodule

// File: tb/tb_ace_rom_bus_if.sv
// tb_ace_rom_bus_if: scoreboard bench for ace_rom_bus_if against a transaction-level ROM read model
module tb_ace_rom_bus_if;
  logic clk = 0, rst = 1;
  logic [15:0] cpu_a = 16'h0;
  logic cpu_mreq_n = 1, cpu_rd_n = 1, cpu_wr_n = 1;
  logic [12:0] rom_a;
  logic [7:0] rom_dout = 8'h00, cpu_din;
  logic rom_sel, cpu_wait_n, wr_viol;
  logic [7:0] mem [0:8191];
  logic [12:0] exp_rom_a;
  int tests = 0, fails = 0;
  typedef struct { logic [7:0] data; int len; } txn_t;
  txn_t sbq[$];
`ifdef ACE_ROM_WAIT_EN
  localparam bit WAIT_EN = 1;
`else
  localparam bit WAIT_EN = 0;
`endif
  ace_rom_bus_if dut (
    .clk(clk), .rst(rst), .cpu_a(cpu_a), .cpu_mreq_n(cpu_mreq_n), .cpu_rd_n(cpu_rd_n),
    .cpu_wr_n(cpu_wr_n), .rom_a(rom_a), .rom_dout(rom_dout), .cpu_din(cpu_din),
    .rom_sel(rom_sel), .cpu_wait_n(cpu_wait_n), .wr_viol(wr_viol)
  );
  always #5 clk = ~clk;
  always @(posedge clk) rom_dout <= mem[rom_a];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // A completed read presents mem[addr] for (active cycles - 2) cycles; shorter reads abort silently.
  task automatic access(input logic [15:0] a, input bit rd, input bit wr, input int len);
    bit hit = a[15:13] == 3'b000;
    @(posedge clk); #1;
    cpu_a = a; cpu_mreq_n = 0; cpu_rd_n = !rd; cpu_wr_n = !wr;
    if (hit && rd) begin
      exp_rom_a = a[12:0];
      if (len >= 3) sbq.push_back('{mem[a[12:0]], len - 2});
    end
    for (int k = 1; k <= len; k++) begin
      @(posedge clk); #1;
      if (k == len) begin cpu_mreq_n = 1; cpu_rd_n = 1; cpu_wr_n = 1; end
      @(negedge clk);
      if (k == 1) chk("rom_a", 32'(rom_a), 32'(exp_rom_a));
      chk("wr_viol", 32'(wr_viol), 32'(hit && wr && k == 1));
      chk("wait_n", 32'(cpu_wait_n), 32'(!(WAIT_EN && hit && rd && (k == 1 || (k == 2 && len >= 2)))));
    end
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask
  initial begin : monitor
    bit in_burst = 0;
    int blen = 0;
    txn_t cur = '{8'h00, 0};
    forever begin
      @(negedge clk);
      if (rst) in_burst = 0;
      else if (rom_sel) begin
        if (!in_burst) begin
          if (sbq.size() == 0) chk("unexpected_rom_sel", 32'(rom_sel), 32'd0);
          else cur = sbq.pop_front();
          in_burst = 1; blen = 0;
        end
        blen++;
        chk("cpu_din", 32'(cpu_din), 32'(cur.data));
      end else begin
        if (in_burst) chk("hold_len", 32'(blen), 32'(cur.len));
        in_burst = 0;
        chk("idle_din", 32'(cpu_din), 32'hFF);
      end
    end
  end
  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
    mem[13'h1234] = 8'hA5;
    exp_rom_a = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_rom_sel", 32'(rom_sel), 32'd0);
    chk("rst_din", 32'(cpu_din), 32'hFF);
    chk("rst_wait_n", 32'(cpu_wait_n), 32'd1);
    chk("rst_rom_a", 32'(rom_a), 32'd0);
    chk("rst_wr_viol", 32'(wr_viol), 32'd0);
    access(16'h1234, 1, 0, 5);
    access(16'h0000, 1, 0, 4);
    access(16'h2000, 1, 0, 4);
    access(16'h0100, 1, 0, 1);
    access(16'h0101, 1, 0, 4);
    access(16'h0100, 1, 0, 2);
    access(16'h0005, 0, 1, 4);
    access(16'h0005, 1, 0, 3);
    access(16'h0006, 1, 1, 4);
    @(posedge clk); #1;
    cpu_a = 16'h0777; cpu_mreq_n = 0; cpu_rd_n = 0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0; cpu_mreq_n = 1; cpu_rd_n = 1;
    exp_rom_a = '0;
    @(negedge clk);
    chk("midrst_rom_sel", 32'(rom_sel), 32'd0);
    chk("midrst_rom_a", 32'(rom_a), 32'd0);
    chk("midrst_wait_n", 32'(cpu_wait_n), 32'd1);
    access(16'h1234, 1, 0, 3);
    for (int i = 0; i < 60; i++) begin
      int t = $urandom_range(0, 3);
      logic [15:0] a = {($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000, 13'($urandom)};
      access(a, t != 2, t >= 2, $urandom_range(1, 6));
    end
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ace_rom_bus_if.md
# ace_rom_bus_if

Bridge between the Jupiter Ace CPU memory bus and the 8 KB synchronous-read system ROM. The block decodes CPU reads in 0x0000–0x1FFF and registers the ROM address. It absorbs the ROM's one-cycle read latency, latches the returned byte and presents it to the CPU data-bus multiplexer. When compiled in, it stretches the CPU cycle with a wait request until the data is valid.

## Interface
Parameters:
- `ROM_BASE_HI`, default 3'b000: value of cpu_a[15:13] that selects the ROM.
- `IDLE_DATA`, default 8'hFF: value driven on cpu_din while the ROM is not selected.

Ports:
- `clk` in 1: system clock. This is the only clock.
- `rst` in 1: synchronous, active-high reset.
- `cpu_a` in 16: CPU address bus.
- `cpu_mreq_n` in 1: CPU memory request, active low.
- `cpu_rd_n` in 1: CPU read strobe, active low.
- `cpu_wr_n` in 1: CPU write strobe, active low.
- `rom_a` out 13: registered address to the ROM.
- `rom_dout` in 8: ROM data. It is valid one clk after `rom_a` changes.
- `cpu_din` out 8: data to the CPU bus multiplexer.
- `rom_sel` out 1: high while `cpu_din` carries valid ROM data.
- `cpu_wait_n` out 1: wait request to the CPU, active low, registered.
- `wr_viol` out 1: one-cycle pulse when a write to the ROM region starts.

## Operation
- `hit` = (cpu_a[15:13] == ROM_BASE_HI) & ~cpu_mreq_n.
- `rd_act` = hit & ~cpu_rd_n.
- `rd_start` = rd_act & ~rd_act_q, where rd_act_q is rd_act registered. The same edge-detect rule applies to writes (`wr_start`).
- FSM states: IDLE, ISSUE, CAPTURE, HOLD.
  - IDLE: on rd_start, load rom_a ← cpu_a[12:0] and go to ISSUE.
  - ISSUE: the ROM samples rom_a at the end of this cycle. If rd_act is low, go to IDLE; otherwise go to CAPTURE.
  - CAPTURE: data_q ← rom_dout. If rd_act is low, go to IDLE and do not update data_q; otherwise go to HOLD.
  - HOLD: rom_sel=1 and cpu_din=data_q. Go to IDLE when rd_act falls. Address changes while in HOLD are ignored.
- In all states other than HOLD: rom_sel=0 and cpu_din=IDLE_DATA.
- rom_a holds its last value in every state except on the IDLE load.
- Back-to-back reads: a rd_start can only occur after rd_act has been low for at least one cycle. Because of that, IDLE is always visited between accesses.
- Writes to the ROM region never modify anything.
  - wr_viol pulses high for exactly one cycle per wr_start.
  - The FSM is unaffected by writes.
- Simultaneous rd and wr strobes (illegal) are treated as a read. wr_viol still pulses.

## Timing
- Reset values: FSM=IDLE, rom_a=0, data_q=8'hFF, cpu_din=IDLE_DATA, rom_sel=0, cpu_wait_n=1, wr_viol=0, rd_act_q=0.
- Reset mid-access forces IDLE on the next edge. The CPU must then see a fresh rd_start.
- Latency, with cycle N being the cycle in which rd_start is seen:
  - N+1: ISSUE.
  - N+2: CAPTURE, with rom_dout valid.
  - N+3: HOLD, with rom_sel=1 and cpu_din valid.
- wr_viol is high in cycle N+1 for a write that starts in cycle N.

## Configuration
- `ACE_ROM_WAIT_EN` defined:
  - cpu_wait_n is driven low from N+1 through N+2 (ISSUE and CAPTURE) and returns high in HOLD.
  - It also returns high immediately on abort to IDLE.
- `ACE_ROM_WAIT_EN` undefined:
  - cpu_wait_n is tied to 1.
  - The system clock ratio must guarantee that the CPU samples data no earlier than N+3.

## Test plan
- Reset held 2 cycles, then released → rom_sel=0, cpu_din=8'hFF, cpu_wait_n=1, rom_a=0.
- Read from 0x1234 with ROM word 0x1234=8'hA5 → rom_a=13'h1234 at N+1; rom_sel=1 and cpu_din=8'hA5 at N+3; rom_sel=0 one cycle after rd_n rises.
- With ACE_ROM_WAIT_EN, read from 0x0000 → cpu_wait_n=0 at N+1 and N+2, =1 at N+3. Without the macro, cpu_wait_n stays 1 throughout.
- Read from 0x2000 (outside the ROM region) → FSM stays IDLE, rom_a unchanged, rom_sel=0.
- Read from 0x0100 aborted (mreq_n rises at N+1) → IDLE at N+2, rom_sel never goes high, data_q holds its previous value. A following read from 0x0101 then completes normally.
- Write to 0x0005 held for 4 cycles → wr_viol high for exactly 1 cycle at N+1, rom_sel=0, ROM content unchanged on a subsequent read.
